// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Purpose : Shared encodings for MIPS control: FSM states, opcodes, functs,
//           ALU control codes and aluop codes.
// Revision: 1.0  initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQ     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module  : alu_decoder
// Purpose : Combinational (aluop, funct) -> alucontrol, plus funct legality.
// Revision: 1.0  initial release
// ============================================================================
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_ok
);

  logic [2:0] w_funct_ctl;

  always_comb begin
    w_funct_ctl = ALU_ADD;
    funct_ok    = 1'b1;
    case (funct)
      F_ADD:   w_funct_ctl = ALU_ADD;
      F_SUB:   w_funct_ctl = ALU_SUB;
      F_AND:   w_funct_ctl = ALU_AND;
      F_OR:    w_funct_ctl = ALU_OR;
      F_SLT:   w_funct_ctl = ALU_SLT;
      default: funct_ok    = 1'b0;
    endcase
  end

  // aluop 11 is unused and falls back to add
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = w_funct_ctl;
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/mips_mc_controller.sv
`default_nettype none
// ============================================================================
// Module  : mips_mc_controller
// Purpose : Multicycle MIPS Moore control FSM with memory-ready stalls and an
//           illegal-instruction pulse.
// Revision: 1.0  initial release
// ============================================================================
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int RESET_HOLD = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  localparam logic [3:0] c_hold_last = 4'(RESET_HOLD - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_hold;
  logic [1:0] w_aluop;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_funct_ok;
  logic       w_bad_instr;

  alu_decoder u_alu_decoder (
    .aluop      (w_aluop),
    .funct      (funct),
    .alucontrol (alucontrol),
    .funct_ok   (w_funct_ok)
  );

  assign w_bad_instr = !((op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
                         (op == OP_ADDI) || (op == OP_J) ||
                         ((op == OP_RTYPE) && w_funct_ok));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_RST;
      r_hold  <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_hold  <= (r_state == S_RST) ? r_hold + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_RST:     w_next_state = (r_hold >= c_hold_last) ? S_FETCH : S_RST;
      S_FETCH:   w_next_state = memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = w_funct_ok ? S_RTYPEEX : S_FETCH;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next_state = memready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next_state = memready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next_state = S_RTYPEWB;
      S_ADDIEX:  w_next_state = S_ADDIWB;
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Strobes in waiting states are qualified by memready so stalls are inert
  always_comb begin
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    iord      = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    illegal   = 1'b0;
    w_aluop   = ALUOP_ADD;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite   = memready;
        w_pcwrite = memready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = w_bad_instr;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = memready;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQ: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen = w_pcwrite | (w_branch & zero);

endmodule : mips_mc_controller
`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_mc_controller
// Purpose : Scoreboard bench: per-cycle expected output vectors are queued
//           with their inputs, then popped and compared at the falling edge.
// Revision: 1.0  initial release
// ============================================================================
module tb_mips_mc_controller;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal;

  typedef logic [16:0] outv_t;
  typedef struct {
    logic  rn;
    logic  mr;
    logic  z;
    outv_t e;
  } item_t;

  item_t sb[$];
  item_t it;
  int    total = 0;
  int    bad   = 0;
  outv_t got;

  assign got = {memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, pcen, alucontrol, illegal};

  mips_mc_controller #(.RESET_HOLD(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memready   (memready),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outv_t mk(input logic mw, iw, rw, io, m2r, rd, asa,
                               input logic [1:0] asb, psrc,
                               input logic pe, input logic [2:0] ac,
                               input logic il);
    return {mw, iw, rw, io, m2r, rd, asa, asb, psrc, pe, ac, il};
  endfunction

  // Expected outputs for each controller step, written from the state table
  function automatic outv_t e_rst();          return mk(0,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0); endfunction
  function automatic outv_t e_fetch(logic m); return mk(0,m,0,0,0,0,0,2'b01,2'b00,m,3'b010,0); endfunction
  function automatic outv_t e_dec(logic il);  return mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,il); endfunction
  function automatic outv_t e_madr();         return mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0); endfunction
  function automatic outv_t e_mrd();          return mk(0,0,0,1,0,0,0,2'b00,2'b00,0,3'b010,0); endfunction
  function automatic outv_t e_mwb();          return mk(0,0,1,0,1,0,0,2'b00,2'b00,0,3'b010,0); endfunction
  function automatic outv_t e_mwr(logic m);   return mk(m,0,0,1,0,0,0,2'b00,2'b00,0,3'b010,0); endfunction
  function automatic outv_t e_rex(logic [2:0] a); return mk(0,0,0,0,0,0,1,2'b00,2'b00,0,a,0); endfunction
  function automatic outv_t e_rwb();          return mk(0,0,1,0,0,1,0,2'b00,2'b00,0,3'b010,0); endfunction
  function automatic outv_t e_beq(logic z);   return mk(0,0,0,0,0,0,1,2'b00,2'b01,z,3'b110,0); endfunction
  function automatic outv_t e_awb();          return mk(0,0,1,0,0,0,0,2'b00,2'b00,0,3'b010,0); endfunction
  function automatic outv_t e_jump();         return mk(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0); endfunction

  task automatic push(input logic rn, input logic mr, input logic z, input outv_t e);
    item_t t;
    t.rn = rn; t.mr = mr; t.z = z; t.e = e;
    sb.push_back(t);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; memready = 1'b1; zero = 1'b0; op = 6'b000010; funct = 6'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (got !== e_rst()) begin
        bad++; $display("FAIL reset_held cyc%0d got=%b want=%b", i, got, e_rst());
      end
      @(posedge clk); #1;
    end
    push(1,1,0,e_rst()); push(1,1,0,e_rst()); push(1,1,0,e_fetch(1));
    push(1,1,0,e_dec(0)); push(1,1,0,e_jump());
    for (int i = 0; sb.size() != 0; i++) begin
      it = sb.pop_front();
      reset_n = it.rn; memready = it.mr; zero = it.z;
      @(negedge clk);
      total++;
      if (got !== it.e) begin
        bad++; $display("FAIL reset_release cyc%0d got=%b want=%b", i, got, it.e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    op = 6'b100011;
    push(1,1,0,e_fetch(1)); push(1,1,0,e_dec(0)); push(1,1,0,e_madr());
    push(1,1,0,e_mrd()); push(1,1,0,e_mwb());
    for (int i = 0; sb.size() != 0; i++) begin
      it = sb.pop_front();
      reset_n = it.rn; memready = it.mr; zero = it.z;
      @(negedge clk);
      total++;
      if (got !== it.e) begin
        bad++; $display("FAIL lw cyc%0d got=%b want=%b", i, got, it.e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [5];
    logic [2:0] ac [5];
    fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ac = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    op = 6'b000000;
    for (int k = 0; k < 5; k++) begin
      funct = fn[k];
      push(1,1,0,e_fetch(1)); push(1,1,0,e_dec(0));
      push(1,1,0,e_rex(ac[k])); push(1,1,0,e_rwb());
      for (int i = 0; sb.size() != 0; i++) begin
        it = sb.pop_front();
        reset_n = it.rn; memready = it.mr; zero = it.z;
        @(negedge clk);
        total++;
        if (got !== it.e) begin
          bad++; $display("FAIL rtype f=%b cyc%0d got=%b want=%b", funct, i, got, it.e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal();
    // bad funct, then bad opcode; each must fall straight back to fetch
    for (int k = 0; k < 2; k++) begin
      op    = (k == 0) ? 6'b000000 : 6'b111111;
      funct = 6'b111111;
      push(1,1,0,e_fetch(1)); push(1,1,0,e_dec(1)); push(1,1,0,e_fetch(1));
      push(1,1,0,e_dec(1));
      for (int i = 0; sb.size() != 0; i++) begin
        it = sb.pop_front();
        reset_n = it.rn; memready = it.mr; zero = it.z;
        @(negedge clk);
        total++;
        if (got !== it.e) begin
          bad++; $display("FAIL illegal op=%b cyc%0d got=%b want=%b", op, i, got, it.e);
        end
        @(posedge clk); #1;
      end
    end
    funct = 6'd0;
  endtask

  task automatic test_beq_addi();
    op = 6'b000100;
    push(1,1,1,e_fetch(1)); push(1,1,1,e_dec(0)); push(1,1,1,e_beq(1));
    push(1,1,0,e_fetch(1)); push(1,1,0,e_dec(0)); push(1,1,0,e_beq(0));
    for (int i = 0; sb.size() != 0; i++) begin
      it = sb.pop_front();
      reset_n = it.rn; memready = it.mr; zero = it.z;
      @(negedge clk);
      total++;
      if (got !== it.e) begin
        bad++; $display("FAIL beq cyc%0d got=%b want=%b", i, got, it.e);
      end
      @(posedge clk); #1;
    end
    op = 6'b001000;
    push(1,1,0,e_fetch(1)); push(1,1,0,e_dec(0)); push(1,1,0,e_madr());
    push(1,1,0,e_awb());
    for (int i = 0; sb.size() != 0; i++) begin
      it = sb.pop_front();
      reset_n = it.rn; memready = it.mr; zero = it.z;
      @(negedge clk);
      total++;
      if (got !== it.e) begin
        bad++; $display("FAIL addi cyc%0d got=%b want=%b", i, got, it.e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_stall();
    op = 6'b101011;
    push(1,0,0,e_fetch(0)); push(1,0,0,e_fetch(0)); push(1,1,0,e_fetch(1));
    push(1,1,0,e_dec(0)); push(1,1,0,e_madr());
    push(1,0,0,e_mwr(0)); push(1,0,0,e_mwr(0)); push(1,0,0,e_mwr(0));
    push(1,1,0,e_mwr(1)); push(1,1,0,e_fetch(1));
    for (int i = 0; sb.size() != 0; i++) begin
      it = sb.pop_front();
      reset_n = it.rn; memready = it.mr; zero = it.z;
      @(negedge clk);
      total++;
      if (got !== it.e) begin
        bad++; $display("FAIL sw_stall cyc%0d got=%b want=%b", i, got, it.e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    op = 6'b101011;
    push(1,1,0,e_dec(0)); push(1,1,0,e_madr());
    for (int i = 0; sb.size() != 0; i++) begin
      it = sb.pop_front();
      reset_n = it.rn; memready = it.mr; zero = it.z;
      @(negedge clk);
      total++;
      if (got !== it.e) begin
        bad++; $display("FAIL areset_pre cyc%0d got=%b want=%b", i, got, it.e);
      end
      @(posedge clk); #1;
    end
    memready = 1'b1;
    @(negedge clk);
    total++;
    if (memwrite !== 1'b1) begin
      bad++; $display("FAIL areset_memwrite_before got=%b want=1", memwrite);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (got !== e_rst()) begin
      bad++; $display("FAIL areset_immediate got=%b want=%b", got, e_rst());
    end
    @(posedge clk); #1;
    push(1,1,0,e_rst()); push(1,1,0,e_rst()); push(1,1,0,e_fetch(1));
    for (int i = 0; sb.size() != 0; i++) begin
      it = sb.pop_front();
      reset_n = it.rn; memready = it.mr; zero = it.z;
      @(negedge clk);
      total++;
      if (got !== it.e) begin
        bad++; $display("FAIL areset_post cyc%0d got=%b want=%b", i, got, it.e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_illegal();
    test_beq_addi();
    test_sw_stall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mips_mc_controller
`default_nettype wire
